peer_link_rx: RTL and testbench

PEER_LINK_RX -- requirements
Module: peer_link_rx

---
 rtl/peer_link_rx.sv | 189 ++++++++++++++++++
 tb/tb_peer_link_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/peer_link_rx.sv
// Serial receiver for the peer-board status link: 13-bit frames (start, 10 data LSB first,
// even parity, stop) are decoded into score/state/add-line, with a link-alive timeout.
//
// state    | meaning
// ---------+------------------------------------------------------------------
// S_IDLE   | line idle, waiting for a synchronized falling edge
// S_START  | half-bit wait, confirm start bit is still low at mid-bit
// S_DATA   | sampling the 10 data bits at mid-bit, LSB first
// S_PARITY | sampling the even-parity bit
// S_STOP   | sampling the stop bit; accept or flag the frame
// S_RESYNC | after a framing error, wait for one full bit time of idle-high line
module peer_link_rx #(
  parameter int CLKS_PER_BIT = 400,
  parameter int TIMEOUT_CLKS = 4000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_line,
  output logic [5:0] score_in,
  output logic [2:0] state_in,
  output logic       add_line,
  output logic       frame_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       link_up
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_RESYNC
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic            r_rx_d;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_bit_idx;
  logic [9:0]      r_shift;
  logic            r_par_ok;
  logic [TW-1:0]   r_to_cnt;

  logic w_rx;
  logic w_fall;
  logic w_cnt_zero;
  logic w_accept;

  assign w_rx       = r_sync2;
  assign w_fall     = r_rx_d & ~w_rx;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_accept   = (r_state == S_STOP) & w_cnt_zero & w_rx & r_par_ok;

  // Synchronizer and edge-detect history idle high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= rx_line;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_par_ok    <= 1'b0;
      score_in    <= '0;
      state_in    <= '0;
      add_line    <= 1'b0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      add_line    <= 1'b0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state <= S_START;
            r_cnt   <= HALF_BIT;
          end
        end
        S_START: begin
          if (w_cnt_zero) begin
            if (!w_rx) begin
              r_state   <= S_DATA;
              r_cnt     <= FULL_M1;
              r_bit_idx <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (w_cnt_zero) begin
            r_shift <= {w_rx, r_shift[9:1]};
            r_cnt   <= FULL_M1;
            if (r_bit_idx == 4'd9) begin
              r_state <= S_PARITY;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_PARITY: begin
          if (w_cnt_zero) begin
            r_par_ok <= ~((^r_shift) ^ w_rx);
            r_cnt    <= FULL_M1;
            r_state  <= S_STOP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (w_cnt_zero) begin
            // Return to IDLE right after the sample so an early next start bit is caught.
            if (w_rx) begin
              r_state <= S_IDLE;
              if (r_par_ok) begin
                score_in    <= r_shift[5:0];
                state_in    <= r_shift[8:6];
                add_line    <= r_shift[9];
                frame_valid <= 1'b1;
              end else begin
                parity_err <= 1'b1;
              end
            end else begin
              framing_err <= 1'b1;
              r_state     <= S_RESYNC;
              r_cnt       <= FULL_M1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESYNC: begin
          if (!w_rx) begin
            r_cnt <= FULL_M1;
          end else if (w_cnt_zero) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Link watchdog: cleared by accepted frames only; error frames do not keep the link alive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      link_up  <= 1'b0;
    end else if (w_accept) begin
      r_to_cnt <= '0;
      link_up  <= 1'b1;
    end else if (r_to_cnt != TO_MAX) begin
      r_to_cnt <= r_to_cnt + 1'b1;
      if (r_to_cnt == TO_LAST) begin
        link_up <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_peer_link_rx.sv
// Scoreboard bench for peer_link_rx: directed frames push expected events, a negedge
// monitor pops and compares whenever the receiver pulses an output.
`timescale 1ns/1ps
module tb_peer_link_rx;

  localparam int N  = 16;
  localparam int TO = 5000;

  logic       clk;
  logic       rst_n;
  logic       rx_line;
  logic [5:0] score_in;
  logic [2:0] state_in;
  logic       add_line;
  logic       frame_valid;
  logic       parity_err;
  logic       framing_err;
  logic       link_up;

  typedef struct packed {
    logic [1:0] kind;   // 0 valid, 1 parity error, 2 framing error
    logic [5:0] score;
    logic [2:0] state;
    logic       add;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   fv_cyc = -1;

  peer_link_rx #(.CLKS_PER_BIT(N), .TIMEOUT_CLKS(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_line     (rx_line),
    .score_in    (score_in),
    .state_in    (state_in),
    .add_line    (add_line),
    .frame_valid (frame_valid),
    .parity_err  (parity_err),
    .framing_err (framing_err),
    .link_up     (link_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [5:0] score,
                      input logic [2:0] state, input logic add);
    exp_t e;
    e.kind = kind; e.score = score; e.state = state; e.add = add;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // rst_bit >= 0 pulses reset in the middle of that data bit.
  task automatic send_frame(input logic [9:0] d, input logic par_flip,
                            input logic stop_v, input int rst_bit);
    logic [12:0] bits;
    bits = {stop_v, (^d) ^ par_flip, d, 1'b0};
    for (int k = 0; k < 13; k++) begin
      rx_line = bits[k];
      if (rst_bit >= 0 && k == rst_bit + 1) begin
        repeat (N/2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_score", int'(score_in), 0);
        check("rst_state", int'(state_in), 0);
        check("rst_link", int'(link_up), 0);
        check("rst_pulses", int'(frame_valid) + int'(parity_err) + int'(framing_err) + int'(add_line), 0);
        rst_n = 1'b1;
        repeat (N/2 - 3) @(negedge clk);
      end else begin
        repeat (N) @(negedge clk);
      end
    end
    rx_line = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && (frame_valid || parity_err || framing_err || add_line)) begin
      check("pulse_exclusive", int'(frame_valid) + int'(parity_err) + int'(framing_err), 1);
      check("add_without_valid", int'(add_line && !frame_valid), 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got fv=%0d pe=%0d fe=%0d add=%0d, expected no pulse",
                 frame_valid, parity_err, framing_err, add_line);
      end else begin
        exp_t e;
        int   kind;
        e    = q.pop_front();
        kind = frame_valid ? 0 : (parity_err ? 1 : 2);
        check("event_kind", kind, int'(e.kind));
        if (e.kind == 2'd0) begin
          check("score_in", int'(score_in), int'(e.score));
          check("state_in", int'(state_in), int'(e.state));
          check("add_line", int'(add_line), int'(e.add));
          check("link_up_on_valid", int'(link_up), 1);
          fv_cyc = cyc;
        end
      end
    end
  end

  initial begin
    int fall_cyc;
    rx_line = 1'b1;
    rst_n   = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_score", int'(score_in), 0);
    check("reset_state", int'(state_in), 0);
    check("reset_fv", int'(frame_valid), 0);
    check("reset_add", int'(add_line), 0);
    check("reset_perr", int'(parity_err), 0);
    check("reset_ferr", int'(framing_err), 0);
    check("reset_link", int'(link_up), 0);
    rst_n = 1'b1;
    idle(2*N);

    // 0x2A5: score 37, state 2, add_line 1, parity bit 1
    push(2'd0, 6'd37, 3'd2, 1'b1);
    send_frame(10'h2A5, 1'b0, 1'b1, -1);
    idle(N);

    push(2'd1, 6'd0, 3'd0, 1'b0);
    send_frame(10'h2A5, 1'b1, 1'b1, -1);
    idle(N);
    check("held_score_after_perr", int'(score_in), 37);
    check("held_state_after_perr", int'(state_in), 2);

    // 0x0D3: score 19, state 3, add_line 0
    push(2'd0, 6'd19, 3'd3, 1'b0);
    send_frame(10'h0D3, 1'b0, 1'b1, -1);
    idle(N);

    // low stop bit, then a frame after only half a bit of idle is ignored,
    // then 0x3C1 (score 1, state 7, add_line 1) after a full idle bit is accepted
    push(2'd2, 6'd0, 3'd0, 1'b0);
    push(2'd0, 6'd1, 3'd7, 1'b1);
    send_frame(10'h155, 1'b0, 1'b0, -1);
    idle(N/2);
    send_frame(10'h000, 1'b0, 1'b1, -1);
    idle(N);
    send_frame(10'h3C1, 1'b0, 1'b1, -1);
    idle(N);
    check("held_score_after_ferr", int'(score_in), 1);

    // short low glitch on the idle line
    rx_line = 1'b0;
    repeat (N/4) @(negedge clk);
    idle(2*N);

    // 0x06B: score 43, state 1, add_line 0
    push(2'd0, 6'd43, 3'd1, 1'b0);
    send_frame(10'h06B, 1'b0, 1'b1, -1);

    fall_cyc = -1;
    for (int i = 0; i < TO + 100; i++) begin
      @(negedge clk);
      if (!link_up) begin
        fall_cyc = cyc;
        break;
      end
    end
    check("timeout_cycles", fall_cyc - fv_cyc, TO);
    idle(10);
    check("score_retained", int'(score_in), 43);
    check("state_retained", int'(state_in), 1);
    check("link_down", int'(link_up), 0);

    // reset during data bit 5; the remainder of 0x3E3 is all high
    send_frame(10'h3E3, 1'b0, 1'b1, 5);
    idle(2*N);
    check("post_abort_score", int'(score_in), 0);
    push(2'd0, 6'd37, 3'd2, 1'b1);
    send_frame(10'h2A5, 1'b0, 1'b1, -1);
    idle(2*N);

    check("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
